moving_ave_seq: RTL and testbench
=================================

Name: moving_ave_seq

Overview:
Frame sequencer in front of the shared MOVING_AVE core. On command it primes the core history with FLUSH_LEN zero samples and discards their results. It then streams exactly CMD_LEN upstream samples through the core, forwards the matching results downstream, drains outstanding results and reports DONE, ERR and ABORTED. It sits between the sample source and MOVING_AVE and is the only master of the core's Avalon-ST ports.

Parameters:
DATA_W, 16, sample and result width (matches core)
LEN_W, 16, width of the frame length command
FLUSH_LEN, 8, number of zero priming samples (equals core window depth); must be >= 1
MAX_OUTST, 4, maximum core inputs accepted but not yet answered by ASO_VALID
ERR_CNT_W, 8, width of the saturating error counter

Ports:
CLK  in  1  clock, all logic on rising edge
RESET_n  in  1  asynchronous active-low reset; one clock, no other clock domains
CMD_START  in  1  one-cycle pulse, start frame (sampled in IDLE only)
CMD_LEN  in  LEN_W  number of samples in the frame, sampled with CMD_START
CMD_ABORT  in  1  one-cycle pulse, abort current frame
BUSY  out  1  high from the cycle after an accepted start until DONE
DONE  out  1  one-cycle pulse at end of frame (normal or aborted)
ERR  out  1  sticky error flag, cleared by accepted CMD_START
ABORTED  out  1  valid with DONE; 1 = frame ended by abort
ERR_CNT  out  ERR_CNT_W  saturating count of error events, cleared by accepted start
ASI_READY  out  1  upstream ready
ASI_VALID  in  1  upstream valid
ASI_DATA  in  DATA_W  upstream sample
CORE_ASI_READY  in  1  core sink ready
CORE_ASI_VALID  out  1  core sink valid
CORE_ASI_DATA  out  DATA_W  core sink data
CORE_ASO_VALID  in  1  core result valid (no backpressure)
CORE_ASO_DATA  in  DATA_W  core result
CORE_ASO_ERROR  in  1  core result error
ASO_VALID  out  1  downstream result valid, one-cycle pulse per result
ASO_DATA  out  DATA_W  downstream result
ASO_ERROR  out  1  downstream error, qualified by ASO_VALID

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0. Assertion mid-frame abandons the frame; no DONE is generated.
- States and transitions:
  - IDLE -> FLUSH on CMD_START & !CMD_ABORT. Latch CMD_LEN, clear ERR and ERR_CNT.
  - If CMD_LEN = 0, go to DONE_ST instead; no core traffic.
  - FLUSH -> RUN once FLUSH_LEN zeros have been accepted.
  - RUN -> DRAIN once CMD_LEN samples have been accepted.
  - DRAIN -> DONE_ST when outstanding = 0.
  - DONE_ST: DONE = 1 for one cycle, then IDLE.
  - CMD_ABORT in FLUSH, RUN or DRAIN -> ABORT_DRAIN. In ABORT_DRAIN, stop issuing, discard all results, and go to DONE_ST with ABORTED = 1 when outstanding = 0.
- Transfer rule: a core input is accepted when CORE_ASI_VALID & CORE_ASI_READY. Outstanding increments on accept and decrements on CORE_ASO_VALID; a simultaneous accept and result leaves it unchanged.
- Issue gate: issue_ok = outstanding < MAX_OUTST, or (outstanding = MAX_OUTST & CORE_ASO_VALID).
- FLUSH: CORE_ASI_VALID = issue_ok, CORE_ASI_DATA = 0, ASI_READY = 0.
- RUN: combinational pass-through.
  - CORE_ASI_VALID = ASI_VALID & issue_ok.
  - ASI_READY = CORE_ASI_READY & issue_ok.
  - CORE_ASI_DATA = ASI_DATA.
- Other states: CORE_ASI_VALID = 0, ASI_READY = 0.
- Result routing: results are numbered in order. The first FLUSH_LEN results are discarded; the next CMD_LEN are forwarded.
  - Forwarded results are registered: ASO_VALID, ASO_DATA and ASO_ERROR appear 1 cycle after CORE_ASO_VALID.
- Error events, each setting ERR and incrementing ERR_CNT, which saturates at all-ones:
  - CORE_ASO_ERROR on any result, including discarded ones;
  - CORE_ASO_VALID while outstanding = 0 (that result is dropped and outstanding stays 0).
- Ignored commands: CMD_START while not IDLE; CMD_ABORT in IDLE or DONE_ST. CMD_START and CMD_ABORT together in IDLE: abort wins and the start is ignored.
- Counters are LEN_W wide; CMD_LEN = 2^LEN_W-1 must complete without wrap.

Decomposition:
- moving_ave_pkg: state enum (IDLE, FLUSH, RUN, DRAIN, ABORT_DRAIN, DONE_ST), default DATA_W, LEN_W and FLUSH_LEN constants.
- One sub-module, moving_ave_credit: outstanding up/down counter with issue_ok and underflow-detect outputs.

Test Plan:
- Normal frame, CMD_LEN=16, FLUSH_LEN=8, real core, ramp input 1..16 -> 8 zeros to core, 0 forwarded during flush; exactly 16 ASO_VALID pulses; ASO_DATA equals golden 8-tap average of 1..16 with zero history; one DONE; ABORTED=0.
- Back-to-back frames with CMD_LEN=4, data 100 each -> second frame's first result = 100/8 = 12, proving the flush cleared history.
- Core model stalls CORE_ASI_READY and delays results 10 cycles -> outstanding never exceeds 4; no sample lost or duplicated.
- CMD_ABORT after 5 RUN samples -> ASI_READY drops the next cycle; no further ASO_VALID; DONE with ABORTED=1 once outstanding=0.
- Core model asserts CORE_ASO_ERROR on result 3, plus one spurious CORE_ASO_VALID while idle-drained -> ERR=1, ERR_CNT=2; the next CMD_START clears both.
- CMD_LEN=0 -> DONE 2 cycles after start; no core traffic. CMD_START while BUSY -> ignored; frame count unchanged.

Source files
------------

// File: rtl/moving_ave_pkg.sv
// +----------------------------------------------------------------------+
// | moving_ave_pkg : shared states and defaults for the MOVING_AVE slice |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package moving_ave_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_FLUSH_LEN = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FLUSH       = 3'd1,
    RUN         = 3'd2,
    DRAIN       = 3'd3,
    ABORT_DRAIN = 3'd4,
    DONE_ST     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/moving_ave_credit.sv
// +----------------------------------------------------------------------+
// | moving_ave_credit : outstanding-request counter with issue gate      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module moving_ave_credit #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             result_valid,
  output logic             issue_ok,
  output logic             underflow,
  output logic [CNT_W-1:0] outstanding
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTST);

  logic dec;

  // A result with nothing in flight is spurious: flag it and leave the count at 0.
  assign underflow = result_valid & (outstanding == '0);
  assign dec       = result_valid & ~underflow;
  assign issue_ok  = (outstanding < LIMIT) | ((outstanding == LIMIT) & result_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (accept && !dec) begin
      outstanding <= outstanding + 1'b1;
    end else if (!accept && dec) begin
      outstanding <= outstanding - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/moving_ave_seq.sv
// +----------------------------------------------------------------------+
// | moving_ave_seq : frame sequencer (flush, stream, drain) for the core |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module moving_ave_seq
  import moving_ave_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN,
  parameter int MAX_OUTST = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic                 CMD_START,
  input  logic [LEN_W-1:0]     CMD_LEN,
  input  logic                 CMD_ABORT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR,
  output logic                 ABORTED,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic                 ASI_READY,
  input  logic                 ASI_VALID,
  input  logic [DATA_W-1:0]    ASI_DATA,
  input  logic                 CORE_ASI_READY,
  output logic                 CORE_ASI_VALID,
  output logic [DATA_W-1:0]    CORE_ASI_DATA,
  input  logic                 CORE_ASO_VALID,
  input  logic [DATA_W-1:0]    CORE_ASO_DATA,
  input  logic                 CORE_ASO_ERROR,
  output logic                 ASO_VALID,
  output logic [DATA_W-1:0]    ASO_DATA,
  output logic                 ASO_ERROR
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int FL_W  = $clog2(FLUSH_LEN + 1);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_LEN - 1);
  localparam logic [FL_W-1:0] FLUSH_ALL  = FL_W'(FLUSH_LEN);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_q, run_cnt;
  logic [FL_W-1:0]    flush_cnt, disc_cnt;
  logic [OUT_W-1:0]   outstanding;
  logic               aborted_q;
  logic               issue_ok, underflow;
  logic               start_ok, accept, result_ok, forward, err_event;

  moving_ave_credit #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (OUT_W)
  ) u_credit (
    .clk          (CLK),
    .rst_n        (RESET_n),
    .accept       (accept),
    .result_valid (CORE_ASO_VALID),
    .issue_ok     (issue_ok),
    .underflow    (underflow),
    .outstanding  (outstanding)
  );

  assign start_ok  = (state == IDLE) & CMD_START & ~CMD_ABORT;
  assign accept    = CORE_ASI_VALID & CORE_ASI_READY;
  assign result_ok = CORE_ASO_VALID & ~underflow;
  // Priming results are consumed by disc_cnt first; only later ones reach downstream.
  assign forward   = result_ok & (disc_cnt == FLUSH_ALL) & ((state == RUN) | (state == DRAIN));
  assign err_event = CORE_ASO_VALID & (CORE_ASO_ERROR | underflow);

  assign BUSY    = (state != IDLE);
  assign DONE    = (state == DONE_ST);
  assign ABORTED = (state == DONE_ST) & aborted_q;

  always_comb begin
    state_nxt      = state;
    CORE_ASI_VALID = 1'b0;
    CORE_ASI_DATA  = '0;
    ASI_READY      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = (CMD_LEN == '0) ? DONE_ST : FLUSH;
      end
      FLUSH: begin
        CORE_ASI_VALID = issue_ok;
        if (CMD_ABORT)                            state_nxt = ABORT_DRAIN;
        else if (accept && flush_cnt == FLUSH_LAST) state_nxt = RUN;
      end
      RUN: begin
        CORE_ASI_VALID = ASI_VALID & issue_ok;
        CORE_ASI_DATA  = ASI_DATA;
        ASI_READY      = CORE_ASI_READY & issue_ok;
        if (CMD_ABORT)                                    state_nxt = ABORT_DRAIN;
        else if (accept && run_cnt == len_q - LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (CMD_ABORT)                state_nxt = ABORT_DRAIN;
        else if (outstanding == '0)   state_nxt = DONE_ST;
      end
      ABORT_DRAIN: begin
        if (outstanding == '0) state_nxt = DONE_ST;
      end
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= IDLE;
      len_q     <= '0;
      run_cnt   <= '0;
      flush_cnt <= '0;
      disc_cnt  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q     <= CMD_LEN;
        run_cnt   <= '0;
        flush_cnt <= '0;
        disc_cnt  <= '0;
        aborted_q <= 1'b0;
      end else begin
        if (state == FLUSH && accept)            flush_cnt <= flush_cnt + 1'b1;
        if (state == RUN && accept)              run_cnt   <= run_cnt + 1'b1;
        if (result_ok && disc_cnt != FLUSH_ALL)  disc_cnt  <= disc_cnt + 1'b1;
        if (state_nxt == ABORT_DRAIN)            aborted_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else if (start_ok) begin
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else if (err_event) begin
      ERR <= 1'b1;
      if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ASO_VALID <= 1'b0;
      ASO_DATA  <= '0;
      ASO_ERROR <= 1'b0;
    end else begin
      ASO_VALID <= forward;
      if (forward) begin
        ASO_DATA  <= CORE_ASO_DATA;
        ASO_ERROR <= CORE_ASO_ERROR;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_moving_ave_seq.sv
// +----------------------------------------------------------------------+
// | tb_moving_ave_seq : directed bench with an 8-tap averaging core model |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_moving_ave_seq;

  localparam int DATA_W = 16, LEN_W = 16, FLUSH_LEN = 8, MAX_OUTST = 4, ERR_CNT_W = 8;

  logic              CLK = 1'b0, RESET_n = 1'b0;
  logic              CMD_START = 1'b0, CMD_ABORT = 1'b0;
  logic [LEN_W-1:0]  CMD_LEN = '0;
  logic              BUSY, DONE, ERR, ABORTED, ASI_READY, CORE_ASI_VALID, ASO_VALID, ASO_ERROR;
  logic [ERR_CNT_W-1:0] ERR_CNT;
  logic              ASI_VALID = 1'b0, CORE_ASI_READY = 1'b0, CORE_ASO_VALID = 1'b0, CORE_ASO_ERROR = 1'b0;
  logic [DATA_W-1:0] ASI_DATA = '0, CORE_ASO_DATA = '0, CORE_ASI_DATA, ASO_DATA;

  moving_ave_seq #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .FLUSH_LEN(FLUSH_LEN), .MAX_OUTST(MAX_OUTST), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .CMD_START(CMD_START), .CMD_LEN(CMD_LEN), .CMD_ABORT(CMD_ABORT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ABORTED(ABORTED), .ERR_CNT(ERR_CNT),
    .ASI_READY(ASI_READY), .ASI_VALID(ASI_VALID), .ASI_DATA(ASI_DATA),
    .CORE_ASI_READY(CORE_ASI_READY), .CORE_ASI_VALID(CORE_ASI_VALID), .CORE_ASI_DATA(CORE_ASI_DATA),
    .CORE_ASO_VALID(CORE_ASO_VALID), .CORE_ASO_DATA(CORE_ASO_DATA), .CORE_ASO_ERROR(CORE_ASO_ERROR),
    .ASO_VALID(ASO_VALID), .ASO_DATA(ASO_DATA), .ASO_ERROR(ASO_ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct { int due; logic [DATA_W-1:0] data; } res_t;
  res_t              pend[$];
  logic [DATA_W-1:0] hist [8];
  logic [DATA_W-1:0] src_q[$], core_in_q[$], out_q[$];
  int  cyc, sum, core_lat, res_idx, err_idx, outst_m, max_outst, done_cnt, asi_seen, outst_at_done, src_pops;
  bit  stall, spur_req, last_aborted;
  int  total, bad;
  int  exp_ramp[16] = '{0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};

  // Core and source model: drive at negedge, observe 1ns before the rising edge.
  initial begin
    for (int i = 0; i < 8; i++) hist[i] = '0;
    cyc = 0; core_lat = 1; err_idx = -1; outst_m = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      CORE_ASO_VALID = 1'b0;
      CORE_ASO_ERROR = 1'b0;
      if (spur_req) begin
        CORE_ASO_VALID = 1'b1;
        CORE_ASO_DATA  = 16'hDEAD;
        spur_req       = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        CORE_ASO_VALID = 1'b1;
        CORE_ASO_DATA  = pend[0].data;
        CORE_ASO_ERROR = (res_idx == err_idx);
        res_idx++;
        outst_m--;
        void'(pend.pop_front());
      end
      CORE_ASI_READY = stall ? (cyc % 3 != 0) : 1'b1;
      ASI_VALID      = (src_q.size() > 0);
      ASI_DATA       = ASI_VALID ? src_q[0] : '0;
      #4;
      if (CORE_ASI_VALID) asi_seen++;
      if (CORE_ASI_VALID && CORE_ASI_READY) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = CORE_ASI_DATA;
        sum = 0;
        for (int i = 0; i < 8; i++) sum += int'(hist[i]);
        pend.push_back('{cyc + core_lat, 16'(sum / 8)});
        core_in_q.push_back(CORE_ASI_DATA);
        outst_m++;
        if (outst_m > max_outst) max_outst = outst_m;
      end
      if (ASI_VALID && ASI_READY) begin
        void'(src_q.pop_front());
        src_pops++;
      end
      if (ASO_VALID) out_q.push_back(ASO_DATA);
      if (DONE) begin
        done_cnt++;
        last_aborted  = ABORTED;
        outst_at_done = outst_m;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, got no summary expected summary");
    $fatal(1);
  end

  task automatic clear_stats();
    out_q.delete(); core_in_q.delete();
    done_cnt = 0; asi_seen = 0; max_outst = 0; res_idx = 0; err_idx = -1; src_pops = 0;
  endtask

  task automatic start_frame(input int len);
    CMD_START = 1'b1;
    CMD_LEN   = LEN_W'(len);
    @(negedge CLK);
    CMD_START = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    #2;
    total++; if (BUSY !== 1'b0)            begin bad++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    total++; if (DONE !== 1'b0)            begin bad++; $display("FAIL reset_done: got %b expected 0", DONE); end
    total++; if (ERR !== 1'b0)             begin bad++; $display("FAIL reset_err: got %b expected 0", ERR); end
    total++; if (ERR_CNT !== '0)           begin bad++; $display("FAIL reset_err_cnt: got %0d expected 0", ERR_CNT); end
    total++; if (ASO_VALID !== 1'b0)       begin bad++; $display("FAIL reset_aso_valid: got %b expected 0", ASO_VALID); end
    total++; if (CORE_ASI_VALID !== 1'b0)  begin bad++; $display("FAIL reset_core_valid: got %b expected 0", CORE_ASI_VALID); end
    total++; if (ASI_READY !== 1'b0)       begin bad++; $display("FAIL reset_asi_ready: got %b expected 0", ASI_READY); end
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_normal();
    bit ok;
    int nz;
    clear_stats(); core_lat = 1; stall = 1'b0;
    for (int i = 1; i <= 16; i++) src_q.push_back(16'(i));
    start_frame(16);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL normal_busy: got %b expected 1", BUSY); end
    wait_done(1, 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL normal_timeout: got no DONE expected DONE"); end
    repeat (3) @(negedge CLK);
    total++; if (done_cnt != 1)       begin bad++; $display("FAIL normal_done_cnt: got %0d expected 1", done_cnt); end
    total++; if (last_aborted !== 1'b0) begin bad++; $display("FAIL normal_aborted: got %b expected 0", last_aborted); end
    total++; if (core_in_q.size() != 24) begin bad++; $display("FAIL normal_core_inputs: got %0d expected 24", core_in_q.size()); end
    nz = 0;
    for (int i = 0; i < 8 && i < core_in_q.size(); i++) if (core_in_q[i] != 0) nz++;
    total++; if (nz != 0) begin bad++; $display("FAIL normal_flush_zeros: got %0d nonzero expected 0", nz); end
    total++; if (out_q.size() != 16) begin bad++; $display("FAIL normal_out_cnt: got %0d expected 16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < out_q.size()) begin
        total++;
        if (int'(out_q[i]) != exp_ramp[i]) begin
          bad++; $display("FAIL normal_out[%0d]: got %0d expected %0d", i, out_q[i], exp_ramp[i]);
        end
      end
    end
    total++; if (outst_at_done != 0) begin bad++; $display("FAIL normal_outst_at_done: got %0d expected 0", outst_at_done); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL normal_busy_end: got %b expected 0", BUSY); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp4[4] = '{12, 25, 37, 50};
    clear_stats(); core_lat = 1; stall = 1'b0;
    for (int i = 0; i < 8; i++) src_q.push_back(16'd100);
    start_frame(4);
    wait_done(1, 200, ok);
    start_frame(4);
    wait_done(2, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d DONEs expected 2", done_cnt); end
    repeat (3) @(negedge CLK);
    total++; if (out_q.size() != 8) begin bad++; $display("FAIL b2b_out_cnt: got %0d expected 8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < out_q.size()) begin
        total++;
        if (int'(out_q[i]) != exp4[i % 4]) begin
          bad++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, out_q[i], exp4[i % 4]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_stats(); core_lat = 10; stall = 1'b1;
    for (int i = 0; i < 12; i++) src_q.push_back(16'd80);
    start_frame(12);
    wait_done(1, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no DONE expected DONE"); end
    repeat (3) @(negedge CLK);
    stall = 1'b0;
    total++; if (max_outst > MAX_OUTST) begin bad++; $display("FAIL stall_max_outst: got %0d expected <= %0d", max_outst, MAX_OUTST); end
    total++; if (core_in_q.size() != 20) begin bad++; $display("FAIL stall_core_inputs: got %0d expected 20", core_in_q.size()); end
    total++; if (out_q.size() != 12) begin bad++; $display("FAIL stall_out_cnt: got %0d expected 12", out_q.size()); end
    for (int i = 0; i < 12; i++) begin
      if (i < out_q.size()) begin
        total++;
        if (int'(out_q[i]) != ((i < 8) ? 10 * (i + 1) : 80)) begin
          bad++; $display("FAIL stall_out[%0d]: got %0d expected %0d", i, out_q[i], (i < 8) ? 10 * (i + 1) : 80);
        end
      end
    end
    total++; if (last_aborted !== 1'b0) begin bad++; $display("FAIL stall_aborted: got %b expected 0", last_aborted); end
  endtask

  task automatic test_abort();
    bit ok;
    int mark, pops_mark;
    clear_stats(); core_lat = 3; stall = 1'b0;
    for (int i = 0; i < 20; i++) src_q.push_back(16'd8);
    start_frame(20);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (src_pops >= 5) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL abort_reach_run: got %0d samples expected 5", src_pops); end
    CMD_ABORT = 1'b1;
    @(negedge CLK);
    CMD_ABORT = 1'b0;
    #2;
    total++; if (ASI_READY !== 1'b0) begin bad++; $display("FAIL abort_asi_ready: got %b expected 0", ASI_READY); end
    @(negedge CLK);
    mark = out_q.size(); pops_mark = src_pops;
    wait_done(1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_timeout: got no DONE expected DONE"); end
    repeat (3) @(negedge CLK);
    total++; if (out_q.size() != mark) begin bad++; $display("FAIL abort_no_more_out: got %0d expected %0d", out_q.size(), mark); end
    total++; if (src_pops != pops_mark) begin bad++; $display("FAIL abort_no_more_in: got %0d expected %0d", src_pops, pops_mark); end
    total++; if (last_aborted !== 1'b1) begin bad++; $display("FAIL abort_flag: got %b expected 1", last_aborted); end
    total++; if (outst_at_done != 0) begin bad++; $display("FAIL abort_outst_at_done: got %0d expected 0", outst_at_done); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL abort_done_cnt: got %0d expected 1", done_cnt); end
    src_q.delete();
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_error();
    bit ok;
    clear_stats(); core_lat = 1; stall = 1'b0; err_idx = 2;
    for (int i = 0; i < 4; i++) src_q.push_back(16'd8);
    start_frame(4);
    wait_done(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL err_timeout: got no DONE expected DONE"); end
    repeat (2) @(negedge CLK);
    spur_req = 1'b1;
    repeat (4) @(negedge CLK);
    err_idx = -1;
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL err_flag: got %b expected 1", ERR); end
    total++; if (ERR_CNT !== 8'd2) begin bad++; $display("FAIL err_cnt: got %0d expected 2", ERR_CNT); end
    total++; if (out_q.size() != 4) begin bad++; $display("FAIL err_out_cnt: got %0d expected 4", out_q.size()); end
    if (out_q.size() > 3) begin
      total++; if (out_q[3] != 16'd4) begin bad++; $display("FAIL err_out_last: got %0d expected 4", out_q[3]); end
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    start_frame(0);
    @(negedge CLK);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done: got %0d expected 1", done_cnt); end
    total++; if (last_aborted !== 1'b0) begin bad++; $display("FAIL zero_aborted: got %b expected 0", last_aborted); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL zero_err_clear: got %b expected 0", ERR); end
    total++; if (ERR_CNT !== '0) begin bad++; $display("FAIL zero_err_cnt_clear: got %0d expected 0", ERR_CNT); end
    repeat (3) @(negedge CLK);
    total++; if (asi_seen != 0) begin bad++; $display("FAIL zero_core_traffic: got %0d expected 0", asi_seen); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_stats(); core_lat = 1; stall = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(16'd16);
    start_frame(6);
    repeat (4) @(negedge CLK);
    start_frame(2);
    wait_done(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_timeout: got no DONE expected DONE"); end
    repeat (8) @(negedge CLK);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_frame_cnt: got %0d expected 1", done_cnt); end
    total++; if (core_in_q.size() != 14) begin bad++; $display("FAIL busy_core_inputs: got %0d expected 14", core_in_q.size()); end
    total++; if (out_q.size() != 6) begin bad++; $display("FAIL busy_out_cnt: got %0d expected 6", out_q.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < out_q.size()) begin
        total++;
        if (int'(out_q[i]) != 2 * (i + 1)) begin
          bad++; $display("FAIL busy_out[%0d]: got %0d expected %0d", i, out_q[i], 2 * (i + 1));
        end
      end
    end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL busy_idle_end: got %b expected 0", BUSY); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_normal();
    test_back_to_back();
    test_stall();
    test_abort();
    test_error();
    test_zero_len();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
